// File: rtl/sweep_result_pkg.sv
// Shared types and constants for the sweep result buffer.
package sweep_result_pkg;

    // Default point-index width; memory depth follows from it.
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned MEM_DEPTH      = 2 ** DEF_ADDR_WIDTH;

    // Pairing FSM: idle, or holding one half and waiting for the other.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_P = 2'd1,
        WAIT_M = 2'd2
    } state_t;

    // Which half of a pair the pending register holds.
    typedef enum logic {
        KIND_M = 1'b0,
        KIND_P = 1'b1
    } kind_t;

endpackage

// File: rtl/result_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module result_dpram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: written on commit, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sweep_result_buffer.sv
// Pairs per-point magnitude and phase results arriving with unequal
// latencies, stores each pair in two result memories indexed by point,
// tracks sweep completion and offers a registered host read port.
module sweep_result_buffer
    import sweep_result_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 8,
    parameter int unsigned NUM_POINTS_DEFAULT = 200,
    parameter int unsigned TIMEOUT            = 4096
) (
    input  logic                  clk125,
    input  logic                  areset_n,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] num_points,
    input  logic                  valid_m,
    input  logic [DATA_WIDTH-1:0] modulo,
    input  logic [ADDR_WIDTH-1:0] addr_m,
    input  logic                  valid_p,
    input  logic [DATA_WIDTH-1:0] phase,
    input  logic [ADDR_WIDTH-1:0] addr_p,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   points_done,
    output logic                  sweep_done,
    output logic                  pair_err,
    output logic                  overflow_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] pend_data;
    logic [ADDR_WIDTH-1:0] pend_idx;
    kind_t                 pend_kind;

    logic [CNT_W-1:0]      tmo_cnt;
    logic                  tmo_hit;
    logic [ADDR_WIDTH:0]   target;

    // Next-state decode outputs
    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_idx;
    logic [DATA_WIDTH-1:0] commit_mag;
    logic [DATA_WIDTH-1:0] commit_ph;
    logic                  latch;
    logic [DATA_WIDTH-1:0] latch_data;
    logic [ADDR_WIDTH-1:0] latch_idx;
    kind_t                 latch_kind;
    logic                  err_set;
    logic                  restart;

    // Commit qualification
    logic                  reject;
    logic                  mem_we;

    // Read-port select, captured with the read so rd_data holds steady
    logic                  sel_q;
    logic [DATA_WIDTH-1:0] mag_rdata;
    logic [DATA_WIDTH-1:0] ph_rdata;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // State register; clear forces IDLE ahead of any strobe.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pairing decisions; strobes are ignored during clear.
    always_comb begin
        state_nxt  = state;
        commit     = 1'b0;
        commit_idx = '0;
        commit_mag = '0;
        commit_ph  = '0;
        latch      = 1'b0;
        latch_data = '0;
        latch_idx  = '0;
        latch_kind = KIND_M;
        err_set    = 1'b0;
        restart    = 1'b0;
        if (!clear) begin
            case (state)
                IDLE: begin
                    if (valid_m && valid_p) begin
                        if (addr_m == addr_p) begin
                            commit     = 1'b1;
                            commit_idx = addr_m;
                            commit_mag = modulo;
                            commit_ph  = phase;
                        end else begin
                            err_set    = 1'b1;
                            latch      = 1'b1;
                            latch_data = modulo;
                            latch_idx  = addr_m;
                            latch_kind = KIND_M;
                            state_nxt  = WAIT_P;
                        end
                    end else if (valid_m) begin
                        latch      = 1'b1;
                        latch_data = modulo;
                        latch_idx  = addr_m;
                        latch_kind = KIND_M;
                        state_nxt  = WAIT_P;
                    end else if (valid_p) begin
                        latch      = 1'b1;
                        latch_data = phase;
                        latch_idx  = addr_p;
                        latch_kind = KIND_P;
                        state_nxt  = WAIT_M;
                    end
                end
                WAIT_P: begin
                    // A partner arriving together with a repeat M still
                    // closes the pair; the stray M only raises pair_err.
                    if (valid_p) begin
                        state_nxt = IDLE;
                        if (valid_m) begin
                            err_set = 1'b1;
                        end
                        if (addr_p == pend_idx) begin
                            commit     = 1'b1;
                            commit_idx = pend_idx;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (valid_m) begin
                        err_set    = 1'b1;
                        latch      = 1'b1;
                        latch_data = modulo;
                        latch_idx  = addr_m;
                        latch_kind = KIND_M;
                        restart    = 1'b1;
                    end else if (tmo_hit) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                WAIT_M: begin
                    if (valid_m) begin
                        state_nxt = IDLE;
                        if (valid_p) begin
                            err_set = 1'b1;
                        end
                        if (addr_m == pend_idx) begin
                            commit     = 1'b1;
                            commit_idx = pend_idx;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (valid_p) begin
                        err_set    = 1'b1;
                        latch      = 1'b1;
                        latch_data = phase;
                        latch_idx  = addr_p;
                        latch_kind = KIND_P;
                        restart    = 1'b1;
                    end else if (tmo_hit) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            // In a wait state the pending half fills its own slot and the
            // live input fills the other.
            if (state != IDLE) begin
                commit_mag = (pend_kind == KIND_M) ? pend_data : modulo;
                commit_ph  = (pend_kind == KIND_P) ? pend_data : phase;
            end
        end
    end

    // Commit qualification: out-of-range index or completed sweep blocks the write.
    always_comb begin
        reject = ({1'b0, commit_idx} >= target) || sweep_done || (points_done >= target);
        mem_we = commit && !reject;
    end

    // Pending half-pair, timeout counter, target, count and sticky flags.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            pend_data    <= '0;
            pend_idx     <= '0;
            pend_kind    <= KIND_M;
            tmo_cnt      <= '0;
            target       <= (ADDR_WIDTH+1)'(NUM_POINTS_DEFAULT);
            points_done  <= '0;
            sweep_done   <= 1'b0;
            pair_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            tmo_cnt      <= '0;
            target       <= (num_points == '0) ? (ADDR_WIDTH+1)'(NUM_POINTS_DEFAULT)
                                               : {1'b0, num_points};
            points_done  <= '0;
            sweep_done   <= 1'b0;
            pair_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (latch) begin
                pend_data <= latch_data;
                pend_idx  <= latch_idx;
                pend_kind <= latch_kind;
            end
            if (restart || (state_nxt != state) || (state == IDLE)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (mem_we) begin
                points_done <= points_done + (ADDR_WIDTH+1)'(1);
            end
            if (commit && reject) begin
                overflow_err <= 1'b1;
            end
            if (err_set) begin
                pair_err <= 1'b1;
            end
            if (points_done == target) begin
                sweep_done <= 1'b1;
            end
        end
    end

    // Host read handshake: valid pulse and memory select follow rd_en by one cycle.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            rd_valid <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                sel_q <= rd_sel;
            end
        end
    end

    assign rd_data = sel_q ? ph_rdata : mag_rdata;

    result_dpram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mag_mem (
        .clk   (clk125),
        .rst_n (areset_n),
        .we    (mem_we),
        .waddr (commit_idx),
        .wdata (commit_mag),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (mag_rdata)
    );

    result_dpram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ph_mem (
        .clk   (clk125),
        .rst_n (areset_n),
        .we    (mem_we),
        .waddr (commit_idx),
        .wdata (commit_ph),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ph_rdata)
    );

endmodule
